// File: rtl/mips_debug_pkg.sv
// Shared constants, command/status codes and FSM encoding for the MIPS
// program-load / debug sequencer.
package mips_debug_pkg;

    localparam int SIZE_REGISTER_INST = 32;
    localparam int SIZE_BYTE          = 8;
    localparam int MEM_DEPTH          = 64;
    localparam int ADDR_W             = $clog2(MEM_DEPTH);

    localparam logic [SIZE_BYTE-1:0] CMD_LOAD  = 8'h4C;
    localparam logic [SIZE_BYTE-1:0] CMD_RUN   = 8'h43;
    localparam logic [SIZE_BYTE-1:0] CMD_STEP  = 8'h53;
    localparam logic [SIZE_BYTE-1:0] CMD_NEXT  = 8'h4E;
    localparam logic [SIZE_BYTE-1:0] CMD_END   = 8'h45;

    localparam logic [SIZE_BYTE-1:0] STAT_ACK  = 8'h4B;
    localparam logic [SIZE_BYTE-1:0] STAT_DONE = 8'h44;

    localparam logic [SIZE_REGISTER_INST-1:0] HALT_INSTRUCTION = 32'h0;
    localparam logic [ADDR_W-1:0]             LAST_ADDR        = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_READY,
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP_PULSE,
        ST_REPORT,
        ST_WAIT_TX
    } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs four UART bytes (first byte = MSB) into one instruction word.
// word_o/word_valid_o already include the byte being accepted this cycle.
module byte_word_assembler
    import mips_debug_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          clear_i,
    input  logic                          byte_valid_i,
    input  logic [SIZE_BYTE-1:0]          byte_i,
    output logic [SIZE_REGISTER_INST-1:0] word_o,
    output logic                          word_valid_o
);

    logic [1:0]                    cnt_q;
    logic [SIZE_REGISTER_INST-1:0] word_q;

    assign word_o       = {word_q[SIZE_REGISTER_INST-SIZE_BYTE-1:0], byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/program_load_sequencer.sv
// Debug controller: loads program words from UART into instruction memory,
// then gates the PC for continuous or single-step runs and reports status.
//
// state       | meaning
// ST_IDLE     | waiting for a command byte
// ST_LOAD_BYTE| collecting bytes of the current word
// ST_LOAD_WRITE| write strobe cycle, decide HALT / overflow / next word
// ST_READY    | program loaded, queue 'K'
// ST_RUN      | PC free-running until halt
// ST_STEP_WAIT| waiting for 'N' / 'E' / halt
// ST_STEP_PULSE| single PC advance cycle
// ST_REPORT   | TX start pulse
// ST_WAIT_TX  | waiting for TX completion
module program_load_sequencer
    import mips_debug_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [SIZE_BYTE-1:0]          i_rx_data,
    input  logic                          i_rx_done,
    input  logic                          i_tx_done,
    input  logic                          i_halt_reached,
    output logic [SIZE_REGISTER_INST-1:0] o_inst_data,
    output logic [ADDR_W-1:0]             o_inst_addr,
    output logic                          o_inst_we,
    output logic                          o_pc_enable,
    output logic [SIZE_BYTE-1:0]          o_tx_data,
    output logic                          o_tx_start,
    output logic                          o_overflow
);

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          loaded_q, loaded_d;
    logic [SIZE_REGISTER_INST-1:0] inst_data_q, inst_data_d;
    logic                          we_q, we_d;
    logic                          pc_en_q, pc_en_d;
    logic [SIZE_BYTE-1:0]          tx_data_q, tx_data_d;
    logic                          tx_start_q, tx_start_d;
    logic                          ovf_q, ovf_d;

    logic                          cmd_valid;
    logic                          asm_clear;
    logic                          asm_byte_valid;
    logic [SIZE_REGISTER_INST-1:0] asm_word;
    logic                          asm_word_valid;
    logic                          force_halt;

    assign cmd_valid      = i_rx_done && (state_q == ST_IDLE);
    assign asm_clear      = cmd_valid && (i_rx_data == CMD_LOAD);
    assign asm_byte_valid = i_rx_done && (state_q == ST_LOAD_BYTE);
    // Last memory slot must hold a HALT so the pipeline never runs past the end.
    assign force_halt     = (addr_q == LAST_ADDR) && (asm_word != HALT_INSTRUCTION);

    byte_word_assembler u_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_byte_valid),
        .byte_i       (i_rx_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            loaded_q    <= 1'b0;
            inst_data_q <= '0;
            we_q        <= 1'b0;
            pc_en_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            loaded_q    <= loaded_d;
            inst_data_q <= inst_data_d;
            we_q        <= we_d;
            pc_en_q     <= pc_en_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (i_rx_data == CMD_LOAD)                   state_d = ST_LOAD_BYTE;
                    else if (i_rx_data == CMD_RUN  && loaded_q)  state_d = ST_RUN;
                    else if (i_rx_data == CMD_STEP && loaded_q)  state_d = ST_STEP_WAIT;
                end
            end
            ST_LOAD_BYTE:  if (asm_word_valid) state_d = ST_LOAD_WRITE;
            ST_LOAD_WRITE: state_d = (inst_data_q == HALT_INSTRUCTION) ? ST_READY : ST_LOAD_BYTE;
            ST_READY:      state_d = ST_REPORT;
            ST_RUN:        if (i_halt_reached) state_d = ST_REPORT;
            ST_STEP_WAIT: begin
                // Halt has priority; a byte arriving in the same cycle is dropped.
                if (i_halt_reached)                           state_d = ST_REPORT;
                else if (i_rx_done && i_rx_data == CMD_NEXT)  state_d = ST_STEP_PULSE;
                else if (i_rx_done && i_rx_data == CMD_END)   state_d = ST_REPORT;
            end
            ST_STEP_PULSE: state_d = ST_STEP_WAIT;
            ST_REPORT:     state_d = ST_WAIT_TX;
            ST_WAIT_TX:    if (i_tx_done) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        loaded_d    = loaded_q;
        inst_data_d = inst_data_q;
        tx_data_d   = tx_data_q;
        ovf_d       = ovf_q;
        we_d        = 1'b0;
        pc_en_d     = (state_d == ST_RUN) || (state_d == ST_STEP_PULSE);
        tx_start_d  = (state_d == ST_REPORT);

        case (state_q)
            ST_IDLE: begin
                if (asm_clear) begin
                    addr_d   = '0;
                    loaded_d = 1'b0;
                end else if (state_d != ST_IDLE) begin
                    // A run consumes the loaded program.
                    loaded_d = 1'b0;
                end
            end
            ST_LOAD_BYTE: begin
                if (asm_word_valid) begin
                    we_d        = 1'b1;
                    inst_data_d = force_halt ? HALT_INSTRUCTION : asm_word;
                    if (force_halt) ovf_d = 1'b1;
                end
            end
            ST_LOAD_WRITE: begin
                if (inst_data_q == HALT_INSTRUCTION) loaded_d = 1'b1;
                else                                 addr_d   = addr_q + 1'b1;
            end
            default: ;
        endcase

        if (state_d == ST_REPORT && state_q != ST_REPORT)
            tx_data_d = (state_q == ST_READY) ? STAT_ACK : STAT_DONE;
    end

    assign o_inst_data = inst_data_q;
    assign o_inst_addr = addr_q;
    assign o_inst_we   = we_q;
    assign o_pc_enable = pc_en_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// Directed bench for program_load_sequencer: load, run, step, overflow,
// reset mid-load and command guards.
module tb_program_load_sequencer;

    localparam logic [7:0] B_L = 8'h4C, B_C = 8'h43, B_S = 8'h53, B_N = 8'h4E, B_E = 8'h45;
    localparam logic [7:0] B_K = 8'h4B, B_D = 8'h44;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] inst_data;
    logic [5:0]  inst_addr;
    logic        inst_we, pc_en, tx_start, ovf;
    logic [7:0]  tx_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tx_log [512];
    logic [5:0]  we_addr_log [512];
    logic [31:0] we_data_log [512];
    int tx_n = 0, we_n = 0, pc_cycles = 0, pc_rises = 0;
    int tx_rd = 0;
    logic pc_prev = 1'b0;

    typedef struct {
        logic [7:0] b;
        int         exp_pc;
        int         exp_tx;
    } guard_vec_t;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  exp_addr;
        logic [31:0] exp_data;
    } load_vec_t;

    program_load_sequencer dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx_data      (rx_data),
        .i_rx_done      (rx_done),
        .i_tx_done      (tx_done),
        .i_halt_reached (halt),
        .o_inst_data    (inst_data),
        .o_inst_addr    (inst_addr),
        .o_inst_we      (inst_we),
        .o_pc_enable    (pc_en),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_overflow     (ovf)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (inst_we && we_n < 512) begin
            we_addr_log[we_n] = inst_addr;
            we_data_log[we_n] = inst_data;
            we_n++;
        end
        if (tx_start && tx_n < 512) begin
            tx_log[tx_n] = tx_data;
            tx_n++;
        end
        if (pc_en) pc_cycles++;
        if (pc_en && !pc_prev) pc_rises++;
        pc_prev = pc_en;
    end

    // UART TX model: finishes a byte a few cycles after each start request.
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            repeat (2) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    endtask

    task automatic expect_tx(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (tx_n == tx_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (tx_n == tx_rd) begin
            total++;
            bad++;
            $display("FAIL %s: no TX byte within 100 cycles, expected %0h", name, exp);
        end else begin
            check_val(name, 64'(tx_log[tx_rd]), 64'(exp));
            tx_rd++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic guard_cmd(input string name, input logic [7:0] b);
        int pc0, tx0;
        pc0 = pc_cycles;
        tx0 = tx_n;
        send_byte(b);
        repeat (10) @(negedge clk);
        check_val({name, "_pc"}, 64'(pc_cycles - pc0), 64'd0);
        check_val({name, "_tx"}, 64'(tx_n - tx0), 64'd0);
    endtask

    guard_vec_t gv [5];
    load_vec_t  lv [2];

    initial begin
        int pc0, we0;
        logic [31:0] w;

        gv[0] = '{B_C,   0, 0};
        gv[1] = '{8'h7A, 0, 0};
        gv[2] = '{B_S,   0, 0};
        gv[3] = '{B_N,   0, 0};
        gv[4] = '{B_E,   0, 0};
        lv[0] = '{32'h20010005, 6'd0, 32'h20010005};
        lv[1] = '{32'h00000000, 6'd1, 32'h00000000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs",
                  64'({inst_data, inst_addr, inst_we, pc_en, tx_data, tx_start, ovf}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Commands before any load do nothing.
        for (int i = 0; i < 5; i++) begin
            pc0 = pc_cycles;
            we0 = tx_n;
            send_byte(gv[i].b);
            repeat (10) @(negedge clk);
            check_val($sformatf("guard%0d_pc", i), 64'(pc_cycles - pc0), 64'(gv[i].exp_pc));
            check_val($sformatf("guard%0d_tx", i), 64'(tx_n - we0), 64'(gv[i].exp_tx));
        end

        we0 = we_n;
        send_byte(B_L);
        for (int i = 0; i < 2; i++) send_word(lv[i].word);
        expect_tx("load_ack", B_K);
        check_val("load_we_count", 64'(we_n - we0), 64'd2);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("load%0d_addr", i), 64'(we_addr_log[we0+i]), 64'(lv[i].exp_addr));
            check_val($sformatf("load%0d_data", i), 64'(we_data_log[we0+i]), 64'(lv[i].exp_data));
        end
        check_val("load_no_overflow", 64'(ovf), 64'd0);

        // Continuous run: enable until halt, low on the next registered cycle.
        send_byte(B_C);
        repeat (5) @(negedge clk);
        check_val("run_pc_high", 64'(pc_en), 64'd1);
        @(posedge clk);
        #1 halt = 1'b1;
        @(negedge clk);
        check_val("run_pc_before_halt_edge", 64'(pc_en), 64'd1);
        @(negedge clk);
        check_val("run_pc_after_halt", 64'(pc_en), 64'd0);
        expect_tx("run_done", B_D);
        halt = 1'b0;
        guard_cmd("rerun_without_load", B_C);

        // Reload HALT-only program, then single-step.
        we0 = we_n;
        send_byte(B_L);
        send_word(32'h0);
        expect_tx("reload_ack", B_K);
        check_val("reload_data", 64'(we_data_log[we0]), 64'd0);
        check_val("reload_addr", 64'(we_addr_log[we0]), 64'd0);

        pc0 = pc_cycles;
        we0 = pc_rises;
        send_byte(B_S);
        for (int i = 0; i < 3; i++) begin
            send_byte(B_N);
            repeat (3) @(negedge clk);
        end
        check_val("step_pc_cycles", 64'(pc_cycles - pc0), 64'd3);
        check_val("step_pc_pulses", 64'(pc_rises - we0), 64'd3);
        @(posedge clk);
        #1 rx_data = B_N;
        rx_done = 1'b1;
        halt = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        expect_tx("step_halt_done", B_D);
        check_val("step_halt_no_pulse", 64'(pc_cycles - pc0), 64'd3);
        halt = 1'b0;

        // Overflow: 64 non-zero words; last slot is forced to HALT.
        we0 = we_n;
        send_byte(B_L);
        for (int i = 0; i < 64; i++) begin
            w = {8'hA5, 8'(i), 8'h3C, 8'(i + 1)};
            send_word(w);
        end
        expect_tx("ovf_ack", B_K);
        check_val("ovf_flag", 64'(ovf), 64'd1);
        check_val("ovf_we_count", 64'(we_n - we0), 64'd64);
        for (int i = 0; i < 64; i++) begin
            w = (i == 63) ? 32'h0 : {8'hA5, 8'(i), 8'h3C, 8'(i + 1)};
            check_val($sformatf("ovf%0d_addr", i), 64'(we_addr_log[we0+i]), 64'(i));
            check_val($sformatf("ovf%0d_data", i), 64'(we_data_log[we0+i]), 64'(w));
        end

        // Async reset after two bytes of the third word.
        send_byte(B_L);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_byte(8'h99);
        send_byte(8'hAA);
        check_val("midload_addr_before", 64'(inst_addr), 64'd2);
        #2 rst = 1'b1;
        #1;
        check_val("midload_reset_outputs",
                  64'({inst_data, inst_addr, inst_we, pc_en, tx_data, tx_start, ovf}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        guard_cmd("post_reset_run", B_C);
        guard_cmd("post_reset_step", B_S);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
